// File: rtl/intr_ctrl_n.sv
// -----------------------------------------------------------------------------
// intr_ctrl_n : N-source interrupt controller feeding one intr_req/intr_ack pair
//
// Requests are synchronised, latched as level or edge per source, masked, and
// arbitrated by fixed or rotating priority. The winning source ID is presented
// on vec_id once the CPU acknowledges, and service ends with an EOI write.
//
// Ports
//   sys_clk   in   1        system clock, rising edge
//   reset     in   1        asynchronous, active-low reset
//   irq_in    in   NUM_SRC  raw interrupt lines (asynchronous)
//   io_cs     in   1        register chip select
//   io_rd     in   1        register read strobe
//   io_wr     in   1        register write strobe
//   io_addr   in   2        0 PENDING(R) 1 MASK(RW) 2 MODE(RW) 3 CTRL(R)/EOI(W)
//   io_din    in   32       write data, low NUM_SRC bits used
//   io_dout   out  32       combinational read data, 0 unless io_cs&io_rd
//   intr_req  out  1        registered request to the CPU
//   intr_ack  in   1        one-cycle acknowledge from the CPU
//   vec_id    out  ID_W     ID of the source in service; NUM_SRC = none/spurious
// -----------------------------------------------------------------------------
module intr_ctrl_n #(
   parameter int NUM_SRC = 8,
   parameter int ID_W    = 4,
   parameter bit ROTATE  = 1'b0
) (
   input  logic               sys_clk,
   input  logic               reset,
   input  logic [NUM_SRC-1:0] irq_in,
   input  logic               io_cs,
   input  logic               io_rd,
   input  logic               io_wr,
   input  logic [1:0]         io_addr,
   input  logic [31:0]        io_din,
   output logic [31:0]        io_dout,
   output logic               intr_req,
   input  logic               intr_ack,
   output logic [ID_W-1:0]    vec_id
);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_REQ,
      ST_SERVICE
   } state_t;

   localparam logic [ID_W-1:0] ID_NONE = ID_W'(NUM_SRC);
   localparam logic [ID_W-1:0] ID_LAST = ID_W'(NUM_SRC - 1);

   state_t               state_q;
   logic                 intr_req_q;
   logic [ID_W-1:0]      vec_id_q;
   logic [ID_W-1:0]      last_id_q;
   logic [NUM_SRC-1:0]   s1_q, s2_q, s3_q;
   logic [NUM_SRC-1:0]   pend_q, pend_d;
   logic [NUM_SRC-1:0]   mask_q;
   logic [NUM_SRC-1:0]   mode_q;

   logic [NUM_SRC-1:0]   eligible;
   logic [NUM_SRC-1:0]   rise;
   logic [NUM_SRC-1:0]   clr;
   logic [NUM_SRC-1:0]   din_src;
   logic                 any_elig;
   logic                 reg_wr;
   logic                 eoi;
   logic                 grant;
   logic [ID_W-1:0]      start_idx;
   logic [ID_W-1:0]      hi_id, lo_id, winner;
   logic                 hi_found;
   logic                 unused_din;

   assign din_src    = io_din[NUM_SRC-1:0];
   assign unused_din = ^io_din;
   assign reg_wr     = io_cs & io_wr;
   assign eoi        = reg_wr && (io_addr == 2'd3);
   assign eligible   = pend_q & ~mask_q;
   assign any_elig   = |eligible;
   assign rise       = s2_q & ~s3_q;
   assign grant      = (state_q == ST_REQ) && intr_ack && any_elig;

   // Rotating search begins just after the last serviced source; the reset
   // value of last_id (NUM_SRC-1) therefore starts the search at index 0.
   assign start_idx = (!ROTATE || last_id_q == ID_LAST) ? '0 : last_id_q + 1'b1;

   // Descending scan so the lowest qualifying index is the last one written:
   // hi_id is the first eligible at/after start_idx, lo_id the wrap-around one.
   // NOTE: every variable gets a default before any conditional assignment so
   // no latch is inferred in combinational logic.
   always_comb begin
      hi_id    = ID_NONE;
      lo_id    = ID_NONE;
      hi_found = 1'b0;
      for (int i = NUM_SRC - 1; i >= 0; i--) begin
         if (eligible[i]) begin
            if (ID_W'(i) >= start_idx) begin
               hi_id    = ID_W'(i);
               hi_found = 1'b1;
            end else begin
               lo_id = ID_W'(i);
            end
         end
      end
      winner = hi_found ? hi_id : lo_id;
   end

   // Pending next state. An edge arriving in the grant cycle beats the clear;
   // a MODE write drops pending bits whose mode flips.
   always_comb begin
      clr    = '0;
      pend_d = '0;
      for (int i = 0; i < NUM_SRC; i++) begin
         clr[i]    = grant && (winner == ID_W'(i));
         pend_d[i] = mode_q[i] ? ((pend_q[i] & ~clr[i]) | rise[i]) : s2_q[i];
         if (reg_wr && io_addr == 2'd2 && (mode_q[i] != din_src[i])) begin
            pend_d[i] = 1'b0;
         end
      end
   end

   // NOTE: sequential state uses non-blocking assignments only, so every flop
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge sys_clk or negedge reset) begin
      if (!reset) begin
         s1_q   <= '0;
         s2_q   <= '0;
         s3_q   <= '0;
         pend_q <= '0;
         mask_q <= '1;
         mode_q <= '0;
      end else begin
         s1_q   <= irq_in;
         s2_q   <= s1_q;
         s3_q   <= s2_q;
         pend_q <= pend_d;
         if (reg_wr && io_addr == 2'd1) mask_q <= din_src;
         if (reg_wr && io_addr == 2'd2) mode_q <= din_src;
      end
   end

   always_ff @(posedge sys_clk or negedge reset) begin
      if (!reset) begin
         state_q    <= ST_IDLE;
         intr_req_q <= 1'b0;
         vec_id_q   <= ID_NONE;
         last_id_q  <= ID_LAST;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (any_elig) begin
                  state_q    <= ST_REQ;
                  intr_req_q <= 1'b1;
               end
            end
            ST_REQ: begin
               if (intr_ack) begin
                  // Ack with nothing eligible (masked this cycle) is spurious.
                  state_q    <= ST_SERVICE;
                  intr_req_q <= 1'b0;
                  vec_id_q   <= any_elig ? winner : ID_NONE;
                  if (ROTATE && any_elig) last_id_q <= winner;
               end else if (!any_elig) begin
                  state_q    <= ST_IDLE;
                  intr_req_q <= 1'b0;
               end
            end
            ST_SERVICE: begin
               if (eoi) begin
                  state_q  <= ST_IDLE;
                  vec_id_q <= ID_NONE;
               end
            end
            default: begin
               state_q    <= ST_IDLE;
               intr_req_q <= 1'b0;
               vec_id_q   <= ID_NONE;
            end
         endcase
      end
   end

   always_comb begin
      io_dout = '0;
      if (io_cs && io_rd) begin
         case (io_addr)
            2'd0: io_dout[NUM_SRC-1:0] = pend_q;
            2'd1: io_dout[NUM_SRC-1:0] = mask_q;
            2'd2: io_dout[NUM_SRC-1:0] = mode_q;
            default: begin
               io_dout[31]       = (state_q == ST_SERVICE);
               io_dout[30]       = intr_req_q;
               io_dout[ID_W-1:0] = vec_id_q;
            end
         endcase
      end
   end

   assign intr_req = intr_req_q;
   assign vec_id   = vec_id_q;

endmodule
